// File: rtl/demux_sched_1x5.sv
// Round-robin scheduler driving the select/enable pair of demux_1x5.
// Grants one of five requesters at a time with a bounded hold time and a
// one-cycle break-before-make gap between consecutive grants.
module demux_sched_1x5 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       done,
  output logic [2:0] Sel,
  output logic       E,
  output logic [4:0] grant,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] sel_nx;
  logic [7:0] hold, hold_nx;
  logic       e_nx, busy_nx, timeout_nx;
  logic [4:0] grant_nx;
  logic [2:0] pick, cand;
  logic       found;
  logic       release_req, expire;

  // Reduce a 0..9 sum back into the 0..4 index range.
  function automatic logic [2:0] wrap5(input logic [3:0] v);
    return (v >= 4'd5) ? 3'(v - 4'd5) : v[2:0];
  endfunction

  // Round-robin search: first requesting index at or after ptr, modulo 5.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      cand = wrap5({1'b0, ptr} + 4'(k));
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    sel_nx      = Sel;
    hold_nx     = hold;
    e_nx        = 1'b0;
    grant_nx    = '0;
    busy_nx     = 1'b1;
    timeout_nx  = 1'b0;
    release_req = done || !req[Sel];
    expire      = (hold == HOLD_LAST);
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          sel_nx   = pick;
          hold_nx  = '0;
          e_nx     = 1'b1;
          grant_nx = 5'b00001 << pick;
        end else begin
          busy_nx = 1'b0;
        end
      end
      GRANT: begin
        hold_nx = hold + 8'd1;
        if (release_req || expire) begin
          state_nx = GAP;
          ptr_nx   = wrap5({1'b0, Sel} + 4'd1);
          // done / request drop outrank expiry when they coincide
          timeout_nx = !release_req;
        end else begin
          e_nx     = 1'b1;
          grant_nx = 5'b00001 << Sel;
        end
      end
      GAP: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      Sel     <= '0;
      hold    <= '0;
      E       <= 1'b0;
      grant   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      Sel     <= sel_nx;
      hold    <= hold_nx;
      E       <= e_nx;
      grant   <= grant_nx;
      busy    <= busy_nx;
      timeout <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_demux_sched_1x5.sv
// Directed-vector bench for demux_sched_1x5 (MAX_HOLD = 8).
// Each vector drives inputs on the falling edge and checks the registered
// outputs just after the following rising edge.
module tb_demux_sched_1x5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic       done = 1'b0;
  logic [2:0] Sel;
  logic       E;
  logic [4:0] grant;
  logic       busy;
  logic       timeout;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic       done;
    logic [2:0] sel;
    logic       e;
    logic [4:0] grant;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  demux_sched_1x5 #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .Sel(Sel), .E(E), .grant(grant), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic d,
                              input logic [2:0] s, input logic e, input logic [4:0] g,
                              input logic b, input logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d;
    v.sel = s; v.e = e; v.grant = g; v.busy = b; v.to = t;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rst  = v.rst;
    req  = v.req;
    done = v.done;
    @(posedge clk);
    #1;
    nvec++;
    if ({Sel, E, grant, busy, timeout} !== {v.sel, v.e, v.grant, v.busy, v.to}) begin
      nbad++;
      $display("FAIL %s: got Sel=%0d E=%b grant=%b busy=%b timeout=%b, want Sel=%0d E=%b grant=%b busy=%b timeout=%b",
               name, Sel, E, grant, busy, timeout, v.sel, v.e, v.grant, v.busy, v.to);
    end
  endtask

  initial begin
    // rst req done | Sel E grant busy timeout
    // reset and basic grant / release
    tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(1, 5'b00000, 0, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b00001, 0, 0, 1, 5'b00001, 1, 0));
    tbl.push_back(mk(0, 5'b00001, 1, 0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b00000, 0, 0));
    // round robin from ptr=0, all requesting, done held
    tbl.push_back(mk(1, 5'b11111, 1, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 0, 1, 5'b00001, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 1, 1, 5'b00010, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 1, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 1, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 2, 1, 5'b00100, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 2, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 2, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 3, 1, 5'b01000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 3, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 3, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 4, 1, 5'b10000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 4, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 4, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 0, 1, 5'b00001, 1, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 0, 0, 5'b00000, 0, 0));
    // pointer wrap: grant 4, then 10001 picks 0, then 4
    tbl.push_back(mk(0, 5'b10000, 1, 4, 1, 5'b10000, 1, 0));
    tbl.push_back(mk(0, 5'b10000, 1, 4, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 4, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 0, 1, 5'b00001, 1, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 0, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 4, 1, 5'b10000, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 4, 0, 5'b00000, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 4, 0, 5'b00000, 0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: ptr=0, req=00100 held, done=0 -> 8 grant cycles, timeout pulse, regrant
    for (int i = 1; i <= 8; i++)
      apply(mk(0, 5'b00100, 0, 2, 1, 5'b00100, 1, 0), $sformatf("hold_cyc%0d", i));
    apply(mk(0, 5'b00100, 0, 2, 0, 5'b00000, 1, 1), "timeout_gap");
    apply(mk(0, 5'b00100, 0, 2, 0, 5'b00000, 0, 0), "timeout_idle");
    apply(mk(0, 5'b00100, 0, 2, 1, 5'b00100, 1, 0), "timeout_regrant");
    apply(mk(0, 5'b00100, 1, 2, 0, 5'b00000, 1, 0), "regrant_done");
    apply(mk(0, 5'b00000, 0, 2, 0, 5'b00000, 0, 0), "regrant_idle");

    // Requester drop during 3rd grant cycle: ptr=3, req[1] -> Sel=1
    apply(mk(0, 5'b00010, 0, 1, 1, 5'b00010, 1, 0), "drop_g1");
    apply(mk(0, 5'b00010, 0, 1, 1, 5'b00010, 1, 0), "drop_g2");
    apply(mk(0, 5'b00010, 0, 1, 1, 5'b00010, 1, 0), "drop_g3");
    apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 1, 0), "drop_gap");
    apply(mk(0, 5'b00000, 0, 1, 0, 5'b00000, 0, 0), "drop_idle");

    // done coinciding with hold expiry: ptr=2, req[3] -> Sel=3, no timeout
    for (int i = 1; i <= 8; i++)
      apply(mk(0, 5'b01000, 0, 3, 1, 5'b01000, 1, 0), $sformatf("prec_cyc%0d", i));
    apply(mk(0, 5'b01000, 1, 3, 0, 5'b00000, 1, 0), "prec_gap");
    apply(mk(0, 5'b00000, 0, 3, 0, 5'b00000, 0, 0), "prec_idle");

    // Reset during 2nd grant cycle of Sel=3 (ptr=4)
    apply(mk(0, 5'b01000, 0, 3, 1, 5'b01000, 1, 0), "rstmid_g1");
    apply(mk(0, 5'b01000, 0, 3, 1, 5'b01000, 1, 0), "rstmid_g2");
    apply(mk(1, 5'b01000, 0, 0, 0, 5'b00000, 0, 0), "rstmid_rst");
    apply(mk(0, 5'b01000, 0, 3, 1, 5'b01000, 1, 0), "rstmid_regrant");
    apply(mk(0, 5'b01000, 1, 3, 0, 5'b00000, 1, 0), "rstmid_gap");
    apply(mk(0, 5'b00000, 0, 3, 0, 5'b00000, 0, 0), "rstmid_idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
